// File: rtl/mem_bus_arbiter.sv
// Arbitrates the instruction-fetch and data buses onto one downstream req/ack memory port,
// producing the stall requests the core consumes and an optional no-ack watchdog.
module mem_bus_arbiter #(
    parameter int DATA_FIRST = 1,
    parameter int MAX_WAIT   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_address,
    input  logic        if_load,
    output logic [31:0] if_rdata,
    output logic        ibus_stall_req,
    input  logic [31:0] mem_address,
    input  logic        mem_load,
    input  logic        mem_store,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_en,
    output logic [31:0] mem_rdata,
    output logic        mem_stall_req,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_timeout
);

    typedef enum logic [1:0] {IDLE, IBUS, DBUS} state_t;

    localparam logic [31:0] WAIT_LAST = 32'(MAX_WAIT - 1);

    state_t      state;
    logic        i_done;
    logic        d_done;
    logic [31:0] i_buf;
    logic [31:0] d_buf;
    logic [31:0] i_tag;
    logic [31:0] wait_cnt;

    logic        i_hit;
    logic        ireq;
    logic        dreq;
    logic        d_go;
    logic        i_go;
    logic        busy;
    logic        expire;
    logic        finish;
    logic [31:0] fin_data;

    assign i_hit  = i_done & (i_tag == if_address);
    assign ireq   = if_load & ~i_hit;
    assign dreq   = mem_load | mem_store;
    // A data request whose result is being consumed this cycle must not be granted again.
    assign d_go   = dreq & ~d_done & (~ireq | (DATA_FIRST != 0));
    assign i_go   = ireq & ~d_go;
    assign busy   = (state != IDLE);
    assign expire = (MAX_WAIT != 0) && busy && !bus_ack && (wait_cnt == WAIT_LAST);
    assign finish = busy & (bus_ack | expire);
    assign fin_data = bus_ack ? bus_rdata : 32'h0;

    assign ibus_stall_req = ireq;
    assign mem_stall_req  = dreq & ~d_done;
    assign if_rdata       = i_buf;
    assign mem_rdata      = d_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'h0;
            bus_wdata   <= 32'h0;
            bus_be      <= 4'h0;
            bus_timeout <= 1'b0;
            i_done      <= 1'b0;
            d_done      <= 1'b0;
            i_buf       <= 32'h0;
            d_buf       <= 32'h0;
            i_tag       <= 32'h0;
            wait_cnt    <= 32'h0;
        end else begin
            d_done      <= 1'b0;
            bus_timeout <= 1'b0;
            i_done      <= i_hit & if_load;
            case (state)
                IDLE: begin
                    wait_cnt <= 32'h0;
                    if (d_go) begin
                        bus_req   <= 1'b1;
                        bus_we    <= mem_store;
                        bus_addr  <= mem_address;
                        bus_wdata <= mem_wdata;
                        bus_be    <= mem_byte_en;
                        state     <= DBUS;
                    end else if (i_go) begin
                        bus_req  <= 1'b1;
                        bus_we   <= 1'b0;
                        bus_addr <= if_address;
                        bus_be   <= 4'hF;
                        i_tag    <= if_address;
                        state    <= IBUS;
                    end
                end
                IBUS, DBUS: begin
                    if (finish) begin
                        bus_req     <= 1'b0;
                        bus_timeout <= ~bus_ack;
                        wait_cnt    <= 32'h0;
                        state       <= IDLE;
                        if (state == IBUS) begin
                            i_buf  <= fin_data;
                            i_done <= 1'b1;
                        end else begin
                            d_buf  <= bus_we ? 32'h0 : fin_data;
                            d_done <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized concurrent fetch/data traffic,
// checked by a queue scoreboard against a word-addressed reference memory.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_address;
    logic        if_load;
    logic [31:0] if_rdata;
    logic        ibus_stall_req;
    logic [31:0] mem_address;
    logic        mem_load;
    logic        mem_store;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rdata;
    logic        mem_stall_req;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_timeout;

    mem_bus_arbiter #(.DATA_FIRST(1), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .if_address(if_address), .if_load(if_load), .if_rdata(if_rdata),
        .ibus_stall_req(ibus_stall_req),
        .mem_address(mem_address), .mem_load(mem_load), .mem_store(mem_store),
        .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata),
        .mem_stall_req(mem_stall_req),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_i_q[$];
    logic [31:0] exp_d_q[$];

    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    int fixed_delay = -1;
    bit slave_en    = 1'b1;
    int late_req    = 0;
    int bus_txns    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event expected normal completion", name);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        w = ref_read(a);
        for (int b = 0; b < 4; b++)
            if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[a] = w;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        slv_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Downstream slave: acks after a delay, backed by its own memory.
    initial begin : slave
        int cnt;
        int late_seen;
        logic [31:0] w;
        cnt = -1;
        late_seen = 0;
        bus_ack = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_ack) begin
                bus_ack = 1'b0;
                cnt = -1;
            end else if (late_req != late_seen) begin
                late_seen = late_req;
                bus_ack = 1'b1;
                bus_rdata = 32'hDEAD_BEEF;
            end else if (!slave_en || rst) begin
                cnt = -1;
            end else if (bus_req) begin
                if (cnt < 0) cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
                if (cnt == 0) begin
                    bus_ack = 1'b1;
                    bus_txns++;
                    if (bus_we) begin
                        w = slv_mem.exists(bus_addr) ? slv_mem[bus_addr] : init_word(bus_addr);
                        for (int b = 0; b < 4; b++)
                            if (bus_be[b]) w[8*b +: 8] = bus_wdata[8*b +: 8];
                        slv_mem[bus_addr] = w;
                        bus_rdata = $urandom;
                    end else begin
                        bus_rdata = slv_mem.exists(bus_addr) ? slv_mem[bus_addr] : init_word(bus_addr);
                    end
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: pops expected results whenever an access completes; checks bus attribute stability.
    initial begin : monitor
        logic [31:0] last_ia;
        bit          i_consumed;
        bit          prev_req;
        bit          prev_ack;
        logic [31:0] prev_addr;
        logic [31:0] prev_ctl;
        last_ia = 32'h0;
        i_consumed = 1'b0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_addr = 32'h0;
        prev_ctl = 32'h0;
        forever begin
            @(negedge clk);
            if (!if_load || if_address != last_ia) i_consumed = 1'b0;
            last_ia = if_address;
            if (!rst && if_load && !ibus_stall_req && !i_consumed) begin
                i_consumed = 1'b1;
                if (exp_i_q.size() == 0) fail_now("fetch_unexpected_completion");
                else check("fetch_rdata", if_rdata, exp_i_q.pop_front());
            end
            if (!rst && (mem_load || mem_store) && !mem_stall_req) begin
                if (exp_d_q.size() == 0) fail_now("data_unexpected_completion");
                else check("data_rdata", mem_rdata, exp_d_q.pop_front());
            end
            if (prev_req && bus_req && !prev_ack) begin
                check("bus_addr_stable", bus_addr, prev_addr);
                check("bus_ctl_stable", {27'b0, bus_we, bus_be}, prev_ctl);
            end
            prev_req = bus_req;
            prev_ack = bus_ack;
            prev_addr = bus_addr;
            prev_ctl = {27'b0, bus_we, bus_be};
        end
    end

    task automatic wait_data_done(input string name);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!mem_stall_req) return;
        end
        fail_now(name);
    endtask

    task automatic wait_fetch_done(input string name);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!ibus_stall_req) return;
        end
        fail_now(name);
    endtask

    task automatic run_fetches(input int n);
        logic [31:0] a;
        logic [31:0] prev_a;
        bit          prev_load;
        prev_a = if_address;
        prev_load = if_load;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) begin
                if_load = 1'b0;
                prev_load = 1'b0;
                @(posedge clk);
                #1;
            end
            a = ($urandom_range(0, 3) == 0) ? prev_a : 32'h8000_0000 + ($urandom_range(0, 15) << 2);
            if_address = a;
            if_load = 1'b1;
            if (!prev_load || a != prev_a) exp_i_q.push_back(ref_read(a));
            prev_a = a;
            prev_load = 1'b1;
            wait_fetch_done("rand_fetch_wait");
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        @(posedge clk);
        #1;
        if_load = 1'b0;
    endtask

    task automatic run_datas(input int n);
        logic [31:0] a;
        int          op;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 2) == 0) begin
                mem_load = 1'b0;
                mem_store = 1'b0;
                @(posedge clk);
                #1;
            end
            op = int'($urandom_range(0, 9));
            a = 32'h1000_0000 + ($urandom_range(0, 7) << 2);
            mem_address = a;
            mem_wdata = $urandom;
            mem_byte_en = 4'($urandom_range(0, 15));
            if (op < 5) begin
                mem_load = 1'b1;
                mem_store = 1'b0;
                exp_d_q.push_back(ref_read(a));
            end else begin
                mem_store = 1'b1;
                mem_load = (op == 9);
                ref_write(a, mem_wdata, mem_byte_en);
                exp_d_q.push_back(32'h0);
            end
            wait_data_done("rand_data_wait");
        end
        @(posedge clk);
        #1;
        mem_load = 1'b0;
        mem_store = 1'b0;
    endtask

    initial begin : global_timeout
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin : main
        int  cnt;
        int  txn0;
        bit  seen;
        bit  d_fin;
        rst = 1'b1;
        if_address = 32'h0; if_load = 1'b0;
        mem_address = 32'h0; mem_load = 1'b0; mem_store = 1'b0;
        mem_wdata = 32'h0; mem_byte_en = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_ctl", {27'b0, bus_we, bus_be}, 32'h0);
        check("rst_timeout", 32'(bus_timeout), 32'd0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        rst = 1'b0;

        // Single fetch, ack in third busy cycle.
        preload(32'h8000_0000, 32'h0000_0013);
        fixed_delay = 2;
        @(posedge clk); #1;
        if_address = 32'h8000_0000; if_load = 1'b1;
        exp_i_q.push_back(32'h0000_0013);
        cnt = 0; seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus_req && !seen) begin
                seen = 1'b1;
                check("fetch_bus_we", 32'(bus_we), 32'd0);
                check("fetch_bus_be", 32'(bus_be), 32'hF);
                check("fetch_bus_addr", bus_addr, 32'h8000_0000);
            end
            if (!ibus_stall_req) break;
            cnt++;
        end
        check("fetch_stall_cycles", cnt, 32'd4);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus_req || ibus_stall_req) cnt++;
        end
        check("fetch_hold_no_refetch", cnt, 32'd0);
        @(posedge clk); #1;
        if_address = 32'h8000_0004;
        exp_i_q.push_back(ref_read(32'h8000_0004));
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus_req) cnt++;
            if (!ibus_stall_req) break;
        end
        check("fetch_new_addr_busy_cycles", cnt, 32'd3);
        @(posedge clk); #1;
        if_load = 1'b0;

        // Simultaneous requests: data must be served first.
        fixed_delay = 1;
        txn0 = bus_txns;
        @(posedge clk); #1;
        if_address = 32'h8000_0008; if_load = 1'b1;
        mem_address = 32'h8040_0000; mem_load = 1'b1;
        exp_i_q.push_back(ref_read(32'h8000_0008));
        exp_d_q.push_back(ref_read(32'h8040_0000));
        seen = 1'b0; d_fin = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus_req && !seen) begin
                seen = 1'b1;
                check("first_grant_addr", bus_addr, 32'h8040_0000);
            end
            if (!d_fin && !mem_stall_req) begin
                d_fin = 1'b1;
                check("fetch_stall_spans_data", 32'(ibus_stall_req), 32'd1);
                @(posedge clk); #1;
                mem_load = 1'b0;
            end
            if (!ibus_stall_req) break;
        end
        check("data_done_before_fetch", 32'(d_fin), 32'd1);
        check("simul_txn_count", bus_txns - txn0, 32'd2);
        @(posedge clk); #1;
        if_load = 1'b0;

        // Store with single byte enable.
        fixed_delay = 0;
        txn0 = bus_txns;
        @(posedge clk); #1;
        mem_address = 32'h1000_0000; mem_wdata = 32'h41; mem_byte_en = 4'b0001; mem_store = 1'b1;
        ref_write(32'h1000_0000, 32'h41, 4'b0001);
        exp_d_q.push_back(32'h0);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus_req && !seen) begin
                seen = 1'b1;
                check("store_bus_we", 32'(bus_we), 32'd1);
                check("store_bus_be", 32'(bus_be), 32'b0001);
                check("store_bus_wdata", bus_wdata, 32'h41);
            end
            if (!mem_stall_req) break;
        end
        @(posedge clk); #1;
        mem_store = 1'b0;
        repeat (3) @(negedge clk);
        check("store_single_txn", bus_txns - txn0, 32'd1);
        @(posedge clk); #1;
        mem_address = 32'h1000_0000; mem_load = 1'b1;
        exp_d_q.push_back(ref_read(32'h1000_0000));
        wait_data_done("store_readback_wait");
        @(posedge clk); #1;
        mem_load = 1'b0;

        // Watchdog: no ack ever arrives.
        slave_en = 1'b0;
        @(posedge clk); #1;
        mem_address = 32'h1000_0004; mem_load = 1'b1;
        exp_d_q.push_back(32'h0);
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!mem_stall_req) break;
            if (bus_req) cnt++;
        end
        check("watchdog_busy_cycles", cnt, 32'd8);
        check("watchdog_timeout_pulse", 32'(bus_timeout), 32'd1);
        @(posedge clk); #1;
        mem_load = 1'b0;
        late_req++;
        @(negedge clk);
        check("watchdog_pulse_one_cycle", 32'(bus_timeout), 32'd0);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus_req || bus_timeout || mem_rdata != 32'h0) cnt++;
        end
        check("late_ack_ignored", cnt, 32'd0);

        // Reset in the middle of a data transaction.
        @(posedge clk); #1;
        mem_address = 32'h1000_0008; mem_load = 1'b1;
        exp_d_q.push_back(ref_read(32'h1000_0008));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_req) break;
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_async_bus_req", 32'(bus_req), 32'd0);
        @(negedge clk);
        check("rst_mid_stall", 32'(mem_stall_req), 32'd1);
        rst = 1'b0;
        slave_en = 1'b1;
        fixed_delay = -1;
        wait_data_done("rst_rearb_wait");
        @(posedge clk); #1;
        mem_load = 1'b0;

        // Randomized concurrent traffic.
        fork
            run_fetches(120);
            run_datas(120);
        join
        repeat (5) @(negedge clk);
        check("fetch_queue_empty", 32'(exp_i_q.size()), 32'd0);
        check("data_queue_empty", 32'(exp_d_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one downstream memory port between the CPU instruction-fetch bus and the data bus.
- Fetch side: if_address, if_load, if_rdata, ibus_stall_req. Data side: mem_address, mem_load, mem_store, mem_wdata, mem_byte_en, mem_rdata, mem_stall_req.
- Sequences each access as a multi-cycle req/ack transaction and generates the stall requests the core consumes.
- Sits between the core top level and the SRAM/peripheral bus controller.

Parameters:
DATA_FIRST, 1, 1: data side wins simultaneous requests in IDLE; 0: fetch side wins.
MAX_WAIT, 0, watchdog limit in cycles spent in a busy state without bus_ack; 0 disables the watchdog.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
if_address  in  32  fetch address
if_load  in  1  fetch request, held high while stalled
if_rdata  out  32  fetched instruction
ibus_stall_req  out  1  fetch not yet complete
mem_address  in  32  data address
mem_load  in  1  data read request
mem_store  in  1  data write request
mem_wdata  in  32  store data
mem_byte_en  in  4  store byte enables
mem_rdata  out  32  load data
mem_stall_req  out  1  data access not yet complete
bus_req  out  1  downstream request, held until ack
bus_we  out  1  downstream write
bus_addr  out  32  downstream address
bus_wdata  out  32  downstream write data
bus_be  out  4  downstream byte enables
bus_ack  in  1  one-cycle completion; bus_rdata valid in the same cycle
bus_rdata  in  32  downstream read data
bus_timeout  out  1  one-cycle pulse when the watchdog expires

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; bus_req, bus_we, bus_timeout, i_done, d_done = 0; bus_addr, bus_wdata, bus_be = 0; i_buf, d_buf = 0; i_tag = 0; wait counter = 0.
- Request decode:
  - dreq = mem_load | mem_store.
  - ireq = if_load & ~(i_done & i_tag==if_address).
- FSM states: IDLE, IBUS, DBUS.
- IDLE:
  - Winner by DATA_FIRST when both requests are present, else whichever is present.
  - Data win: latch mem_address, mem_wdata, mem_byte_en, bus_we=mem_store; next state DBUS.
  - Fetch win: latch if_address into bus_addr and i_tag, bus_we=0, bus_be=4'hF; next state IBUS.
  - bus_req asserts the cycle after the decision (registered).
  - bus_ack received in IDLE is ignored.
- IBUS / DBUS:
  - bus_req and attributes stay stable until bus_ack.
  - On ack: capture bus_rdata into i_buf or d_buf (d_buf=0 for a store), set i_done or d_done, drop bus_req, go to IDLE.
  - An in-flight transaction is never aborted, including on a trap or branch redirect.
- i_done:
  - Stays set while if_load=1 and if_address==i_tag.
  - Clears on any change of address or on if_load=0.
  - Hit-held data is never refetched.
- d_done: pulses for exactly one cycle. The core's mem stage never stalls on an ibus stall, so the result is consumed in that cycle and a store is never reissued.
- Output equations:
  - ibus_stall_req = if_load & ~(i_done & i_tag==if_address), combinational.
  - mem_stall_req = dreq & ~d_done, combinational.
  - if_rdata = i_buf; mem_rdata = d_buf.
- Latency: request seen in cycle 0 → bus_req in cycle 1 → ack no earlier than cycle 1 → stall low and data valid in cycle ack+1. Minimum 2 cycles per access.
- Back-to-back: the cycle in which d_done=1 is an IDLE cycle, so a new request can be arbitrated in that same cycle.
- Watchdog (MAX_WAIT>0):
  - The counter increments each busy cycle without ack and clears on leaving a busy state.
  - On reaching MAX_WAIT: treat as ack with rdata=0 and pulse bus_timeout. A late ack then arrives in IDLE and is ignored.
- Reset mid-transaction: bus_req drops immediately (asynchronous reset), all done flags clear, the downstream transaction is abandoned.
- mem_load and mem_store both high is illegal; it is treated as a store.

Test Plan:
- Single fetch: if_load=1, if_address=0x8000_0000, ack after 3 cycles with 0x0000_0013 → ibus_stall_req high for 4 cycles, then low with if_rdata=0x13; bus_we=0, bus_be=F.
- Simultaneous requests, DATA_FIRST=1: mem_load to 0x8040_0000 plus fetch → DBUS served first, mem_stall_req low after its ack, then IBUS; fetch stall spans both transactions.
- Store: mem_store=1, addr 0x1000_0000, wdata 0x41, be=0001 → bus_we=1, bus_be=0001, exactly one bus_req transaction, mem_stall_req low for exactly one cycle.
- Fetch hold: after a fetch completes, keep if_load=1 with the same address for 5 cycles → no new bus_req. Change the address → new transaction starts.
- Watchdog, MAX_WAIT=8, ack never asserted → bus_timeout pulses in the 8th busy cycle, stall drops with rdata=0; a late ack in IDLE has no effect.
- Assert rst during DBUS → bus_req=0 asynchronously, state IDLE; after release, a pending request is re-arbitrated cleanly.
